// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory access stage: FSM states,
// access-size encodings, default bus timeout and the byte-enable helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    // Encoding 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half lane out of a bus read word and
// zero- or sign-extends it to 32 bits.
module load_extender
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & lane_b[7]}}, lane_b};
            SIZE_HALF: load_data = {{16{is_signed & lane_h[15]}}, lane_h};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues one bus request per load/store, stalls the front
// of the pipe until ack or timeout. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
//
// state  | meaning
// IDLE   | no bus activity; a pending load/store issues a request (stall asserted)
// ACCESS | bus_req held with stable address/data, waiting for bus_ack or timeout
// DONE   | result captured, stall released; always returns to IDLE
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        EXMEM_memRead,
    input  logic        EXMEM_memWrite,
    input  logic [1:0]  EXMEM_memSize,
    input  logic        EXMEM_memSigned,
    input  logic [31:0] EXMEM_aluResult,
    input  logic [31:0] EXMEM_writeData,
    output logic [31:0] memReadData,
    output logic        memStall,
    output logic        busError,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e        state, state_next;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              pending, bad_align;
    logic              issue, finish_ack, finish_tmo, skip;
    logic [1:0]        size_eff, addr_lo;
    logic [31:0]       wdata_rep, load_data;
    logic [1:0]        ld_lo, ld_size;
    logic              ld_signed;

    assign pending  = EXMEM_memRead | EXMEM_memWrite;
    assign size_eff = norm_size(EXMEM_memSize);

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_lo   = EXMEM_aluResult[1:0];
    assign bad_align = ((size_eff == SIZE_HALF) && EXMEM_aluResult[0]) ||
                       ((size_eff == SIZE_WORD) && (EXMEM_aluResult[1:0] != 2'b00));
`else
    // Bits below the access size are ignored rather than trapped.
    assign addr_lo   = (size_eff == SIZE_BYTE) ? EXMEM_aluResult[1:0] :
                       (size_eff == SIZE_HALF) ? {EXMEM_aluResult[1], 1'b0} : 2'b00;
    assign bad_align = 1'b0;
`endif

    always_comb begin
        case (size_eff)
            SIZE_BYTE: wdata_rep = {4{EXMEM_writeData[7:0]}};
            SIZE_HALF: wdata_rep = {2{EXMEM_writeData[15:0]}};
            default:   wdata_rep = EXMEM_writeData;
        endcase
    end

    load_extender u_load_extender (
        .rdata     (bus_rdata),
        .addr_lo   (ld_lo),
        .size      (ld_size),
        .is_signed (ld_signed),
        .load_data (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        memStall   = 1'b0;
        issue      = 1'b0;
        finish_ack = 1'b0;
        finish_tmo = 1'b0;
        skip       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    memStall = 1'b1;
                    if (bad_align) begin
                        skip       = 1'b1;
                        state_next = DONE;
                    end else begin
                        issue      = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                memStall = 1'b1;
                if (bus_ack) begin
                    finish_ack = 1'b1;
                    state_next = DONE;
                end else if (tmo_cnt == '0) begin
                    finish_tmo = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timeout is a down-counter loaded on issue; terminal count is zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            memReadData <= '0;
            busError    <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
            tmo_cnt     <= '0;
            ld_lo       <= '0;
            ld_size     <= '0;
            ld_signed   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned  <= 1'b0;
`endif
        end else begin
            busError <= finish_tmo;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned <= skip;
`endif
            if (issue) begin
                bus_req   <= 1'b1;
                bus_we    <= EXMEM_memWrite;
                bus_addr  <= {EXMEM_aluResult[31:2], 2'b00};
                bus_be    <= byte_enables(size_eff, addr_lo);
                bus_wdata <= wdata_rep;
                tmo_cnt   <= CNT_W'(TIMEOUT_CYCLES - 1);
                ld_lo     <= addr_lo;
                ld_size   <= size_eff;
                ld_signed <= EXMEM_memSigned;
            end else if ((state == ACCESS) && (tmo_cnt != '0)) begin
                tmo_cnt <= tmo_cnt - CNT_W'(1);
            end
            if (finish_ack || finish_tmo) bus_req <= 1'b0;
            if (finish_ack)               memReadData <= bus_we ? 32'h0 : load_data;
            if (finish_tmo || skip)       memReadData <= 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed corner cases plus random
// accesses against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        EXMEM_memRead, EXMEM_memWrite, EXMEM_memSigned;
    logic [1:0]  EXMEM_memSize;
    logic [31:0] EXMEM_aluResult, EXMEM_writeData;
    logic [31:0] memReadData;
    logic        memStall, busError;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rd = 32'h0;

    always #5 clock = ~clock;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .EXMEM_memRead   (EXMEM_memRead),
        .EXMEM_memWrite  (EXMEM_memWrite),
        .EXMEM_memSize   (EXMEM_memSize),
        .EXMEM_memSigned (EXMEM_memSigned),
        .EXMEM_aluResult (EXMEM_aluResult),
        .EXMEM_writeData (EXMEM_writeData),
        .memReadData     (memReadData),
        .memStall        (memStall),
        .busError        (busError),
`ifdef MEM_ALIGN_CHECK_EN
        .misaligned      (misaligned),
`endif
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_be          (bus_be),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int eff_size(input logic [1:0] sz);
        return (sz == 2'd3) ? 2 : int'(sz);
    endfunction

    function automatic bit is_misaligned(input int sz, input logic [31:0] addr);
        if (sz == 1) return (addr % 2) != 0;
        if (sz == 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int eff_lo(input int sz, input logic [31:0] addr);
        int l;
        l = int'(addr % 4);
        if (sz == 0) return l;
        if (sz == 1) return l - (l % 2);
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input int lo);
        if (sz == 0) return 4'(1 << lo);
        if (sz == 1) return (lo == 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] wd);
        if (sz == 0) return (wd % 256) * 32'h01010101;
        if (sz == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input int sz, input int lo, input bit sgn,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * lo);
        if (sz == 0) begin
            v = v % 256;
            if (sgn && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic clear_inputs();
        EXMEM_memRead   = 1'b0;
        EXMEM_memWrite  = 1'b0;
        EXMEM_memSize   = 2'd0;
        EXMEM_memSigned = 1'b0;
        EXMEM_aluResult = 32'h0;
        EXMEM_writeData = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Runs one load/store from IDLE through DONE and back to IDLE; acked after `waits` wait states.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz_raw, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits, input string tag);
        int sz, lo, stalls, reqs;
        bit skip;
        sz = eff_size(sz_raw);
        lo = eff_lo(sz, addr);
`ifdef MEM_ALIGN_CHECK_EN
        skip = is_misaligned(sz, addr);
`else
        skip = 1'b0;
`endif
        EXMEM_memRead   = rd;
        EXMEM_memWrite  = wr;
        EXMEM_memSize   = sz_raw;
        EXMEM_memSigned = sgn;
        EXMEM_aluResult = addr;
        EXMEM_writeData = wd;
        bus_ack         = 1'b0;
        #1;
        check({tag, "_idle_stall"}, 32'(memStall), 32'd1);
        stalls = 1;
        reqs   = 0;
        next_cycle();
        if (skip) begin
`ifdef MEM_ALIGN_CHECK_EN
            check({tag, "_misaligned"}, 32'(misaligned), 32'd1);
`endif
            check({tag, "_skip_req"}, 32'(bus_req), 32'd0);
            check({tag, "_skip_stall"}, 32'(memStall), 32'd0);
            check({tag, "_skip_rd"}, memReadData, 32'h0);
            exp_rd = 32'h0;
        end else begin
            check({tag, "_we"}, 32'(bus_we), 32'(wr));
            check({tag, "_addr"}, bus_addr, addr & 32'hFFFFFFFC);
            check({tag, "_be"}, 32'(bus_be), 32'(exp_be(sz, lo)));
            if (wr) check({tag, "_wdata"}, bus_wdata, exp_wdata(sz, wd));
            for (int k = 0; k <= waits; k++) begin
                if (bus_req)  reqs++;
                if (memStall) stalls++;
                bus_ack   = (k == waits);
                bus_rdata = (k == waits) ? rdata : $urandom();
                next_cycle();
                bus_ack = 1'b0;
            end
            exp_rd = wr ? 32'h0 : exp_load(sz, lo, sgn, rdata);
            check({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 2));
            check({tag, "_req_cycles"}, 32'(reqs), 32'(waits + 1));
            check({tag, "_done_stall"}, 32'(memStall), 32'd0);
            check({tag, "_done_req"}, 32'(bus_req), 32'd0);
            check({tag, "_done_rd"}, memReadData, exp_rd);
            check({tag, "_done_berr"}, 32'(busError), 32'd0);
        end
        clear_inputs();
        next_cycle();
        check({tag, "_after_req"}, 32'(bus_req), 32'd0);
        check({tag, "_after_stall"}, 32'(memStall), 32'd0);
        check({tag, "_hold_rd"}, memReadData, exp_rd);
`ifdef MEM_ALIGN_CHECK_EN
        check({tag, "_after_mis"}, 32'(misaligned), 32'd0);
`endif
    endtask

    initial begin
        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        clear_inputs();
        next_cycle();
        next_cycle();
        check("rst_rd", memReadData, 32'h0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_berr", 32'(busError), 32'd0);
        check("rst_stall", 32'(memStall), 32'd0);
        reset = 1'b0;
        next_cycle();

        access(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
        access(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 0, "lb");
        access(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 1, "lbu");
        access(1, 0, 2'd1, 1, 32'h102, 32'h0, 32'h8001F00D, 0, "lh");
        access(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h13572468, 3, "sh");
        access(0, 1, 2'd0, 0, 32'h301, 32'h123456A5, 32'h0, 0, "sb");
        access(1, 0, 2'd3, 0, 32'h104, 32'h0, 32'hCAFEF00D, 2, "lsz3");

        // Timeout: request is never acknowledged.
        EXMEM_memRead   = 1'b1;
        EXMEM_memSize   = 2'd2;
        EXMEM_aluResult = 32'h40;
        #1;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            check("to_req", 32'(bus_req), 32'd1);
            check("to_berr_early", 32'(busError), 32'd0);
            next_cycle();
        end
        check("to_berr", 32'(busError), 32'd1);
        check("to_rd", memReadData, 32'h0);
        check("to_req_drop", 32'(bus_req), 32'd0);
        check("to_done_stall", 32'(memStall), 32'd0);
        clear_inputs();
        next_cycle();
        check("to_berr_pulse", 32'(busError), 32'd0);
        check("to_idle_stall", 32'(memStall), 32'd0);
        exp_rd = 32'h0;

        access(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h55AA55AA, 0, "lw_mis");
        access(1, 1, 2'd2, 0, 32'h108, 32'h0BADF00D, 32'h77777777, 1, "rdwr");

        // Reset lands in the second ACCESS cycle; a late ack must be ignored.
        access(1, 0, 2'd2, 0, 32'h10C, 32'h0, 32'h11223344, 0, "pre_rst");
        EXMEM_memRead   = 1'b1;
        EXMEM_memSize   = 2'd2;
        EXMEM_aluResult = 32'h300;
        #1;
        next_cycle();
        check("rst_acc1_req", 32'(bus_req), 32'd1);
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
        check("rst_acc_req", 32'(bus_req), 32'd0);
        check("rst_acc_stall", 32'(memStall), 32'd0);
        check("rst_acc_rd", memReadData, 32'h0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        next_cycle();
        bus_ack = 1'b0;
        check("late_ack_rd", memReadData, 32'h0);
        check("late_ack_req", 32'(bus_req), 32'd0);
        check("late_ack_stall", 32'(memStall), 32'd0);
        check("late_ack_berr", 32'(busError), 32'd0);
        exp_rd = 32'h0;

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 3);
            access(op != 1, op == 1 || op == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom(), $urandom(), $urandom(), $urandom_range(0, 2), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: ACCESS cycles without bus_ack before abort.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port EXMEM_memRead, input, 1: load in the EX/MEM register.
REQ-005 SHALL have port EXMEM_memWrite, input, 1: store in the EX/MEM register.
REQ-006 SHALL have port EXMEM_memSize, input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 SHALL have port EXMEM_memSigned, input, 1: sign-extend sub-word loads.
REQ-008 SHALL have port EXMEM_aluResult, input, 32: byte address.
REQ-009 SHALL have port EXMEM_writeData, input, 32: store data, right-aligned.
REQ-010 SHALL have port memReadData, output, 32: registered, extended load result, fed to MEM/WB.
REQ-011 SHALL have port memStall, output, 1: freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-012 SHALL have port busError, output, 1: one-cycle pulse on timeout.
REQ-013 SHALL have port bus_req, output, 1: memory request, registered.
REQ-014 SHALL have port bus_we, output, 1: write request.
REQ-015 SHALL have port bus_addr, output, 32: word-aligned address (low two bits 0).
REQ-016 SHALL have port bus_wdata, output, 32: lane-replicated store data.
REQ-017 SHALL have port bus_be, output, 4: byte enables.
REQ-018 SHALL have port bus_ack, input, 1: completes the request in the same cycle.
REQ-019 SHALL have port bus_rdata, input, 32: read word, valid when bus_ack=1.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-021 SHALL, in IDLE with memRead or memWrite asserted, go to ACCESS; otherwise stay in IDLE.
REQ-022 SHALL drive memStall combinationally = (IDLE and access pending) or ACCESS; memStall=0 in DONE.
REQ-023 SHALL, while in ACCESS, hold bus_req=1 and keep bus_addr, bus_we, bus_be and bus_wdata stable.
REQ-024 SHALL, on bus_ack in ACCESS, capture the extended load into memReadData (0 for stores), drop bus_req and go to DONE.
REQ-025 SHALL go from DONE to IDLE unconditionally, so each instruction issues exactly one request; a zero-wait-state access therefore takes 3 cycles.
REQ-026 SHALL count ACCESS cycles and, when the count reaches TIMEOUT_CYCLES with no ack, go to DONE, set memReadData=0 and pulse busError.
REQ-027 SHALL generate byte enables as follows:
- byte: bus_be = 1 << addr[1:0];
- half: bus_be = addr[1] ? 1100 : 0011;
- word: bus_be = 1111.
REQ-028 SHALL replicate store data across lanes: byte to all four lanes, half to both halves.
REQ-029 SHALL select the load lane from addr[1:0], then zero- or sign-extend it per EXMEM_memSigned.
REQ-030 SHALL treat memRead and memWrite both asserted as a store.
REQ-031 SHALL hold memReadData between accesses.

Reset
REQ-032 SHALL, on reset, set the state to IDLE and clear memReadData, the count, bus_req, bus_we, bus_addr, bus_wdata, bus_be and busError to 0.
REQ-033 SHALL, on reset during ACCESS, drop bus_req at that edge and ignore any bus_ack in the following cycle.

Configuration
REQ-034 SHALL, with MEM_ALIGN_CHECK_EN defined, treat a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) as follows:
- go from IDLE directly to DONE with no bus request;
- pulse output misaligned for one cycle;
- set memReadData=0.
REQ-035 SHALL, without MEM_ALIGN_CHECK_EN, omit the misaligned port and force the ignored low address bits to zero, then proceed normally.

Structure
REQ-036 SHALL take the state enum, the memSize encodings and the default TIMEOUT_CYCLES from shared package mem_stage_pkg.
REQ-037 SHALL place lane select and extension in combinational sub-module load_extender.

Verification
REQ-038 SHALL cover: lw at addr 0x100, bus_ack in first ACCESS cycle, rdata 0xDEADBEEF -> memStall high 2 cycles, memReadData=0xDEADBEEF in DONE, exactly one bus_req.
REQ-039 SHALL cover: lb signed at addr 0x103, rdata 0x80112233 -> bus_be=1000, memReadData=0xFFFFFF80; lbu -> 0x00000080.
REQ-040 SHALL cover: sh at addr 0x202, writeData 0x0000ABCD, 3 wait states -> bus_be=1100, bus_wdata=0xABCDABCD, memStall high 5 cycles.
REQ-041 SHALL cover: no bus_ack, TIMEOUT_CYCLES=4 -> busError pulse after 4 ACCESS cycles, memReadData=0, FSM back in IDLE.
REQ-042 SHALL cover: reset asserted in the 2nd ACCESS cycle -> bus_req=0 and memStall=0 next cycle, and a late bus_ack is ignored.
REQ-043 SHALL cover: lw at addr 0x101 -> with MEM_ALIGN_CHECK_EN, misaligned pulse and no bus_req; without it, bus_addr=0x100.
